mux_arb: RTL

- Parametrised, registered N-channel multiplexer with per-channel valid/ready handshake.
- Successor to the 2:1 combinational mux; replaces the bare select with a sequential arbiter.
- Three arbitration modes: fixed priority, round-robin, and forced select.
- Sits between several producer channels and one shared consumer, e.g. a shared datapath or output port.

---
 rtl/mux_arb.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux_arb.sv
// mux_arb: registered N-channel multiplexer with valid/ready handshake.
// Arbitration is fixed priority, round-robin or forced select. The output
// register is loaded whenever it is empty or being drained, so a streaming
// consumer sees one word per clock with no bubbles.
module mux_arb #(
  parameter  int N_CH    = 4,
  parameter  int BW_DATA = 4,
  localparam int BW_SEL  = $clog2(N_CH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [1:0]                i_mode,
  input  logic [BW_SEL-1:0]         i_sel,
  input  logic [N_CH-1:0]           i_valid,
  input  logic [N_CH*BW_DATA-1:0]   i_data,
  output logic [N_CH-1:0]           o_ready,
  output logic                      o_valid,
  output logic [BW_DATA-1:0]        o_data,
  output logic [BW_SEL-1:0]         o_ch,
  input  logic                      i_ready
);

  localparam logic [1:0] MODE_RR     = 2'd1;
  localparam logic [1:0] MODE_FORCED = 2'd2;

  logic [BW_DATA-1:0] ch_data [N_CH];
  logic [N_CH-1:0]    cand;
  logic [N_CH-1:0]    search;
  logic [N_CH-1:0]    grant;
  logic               grant_any;
  logic [BW_SEL-1:0]  grant_idx;
  logic [BW_DATA-1:0] grant_data;
  logic [BW_SEL-1:0]  ptr_reg;
  logic               load;

  // Unpack the flattened data bus into one word per channel.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch_data[gi] = i_data[gi*BW_DATA +: BW_DATA];
  end

  // The output register can take a new word when empty or being drained.
  assign load = ~o_valid | i_ready;

  // Candidate requests per mode. Round-robin first searches from the
  // pointer upwards; the lower channels are the wrap-around fallback.
  always_comb begin
    cand = '0;
    for (int k = 0; k < N_CH; k++) begin
      case (i_mode)
        MODE_RR:     cand[k] = i_valid[k] && (k >= int'(ptr_reg));
        MODE_FORCED: cand[k] = i_valid[k] && (k == int'(i_sel));
        default:     cand[k] = i_valid[k];
      endcase
    end
    search = ((i_mode == MODE_RR) && (cand == '0)) ? i_valid : cand;
  end

  // Lowest set bit of the search vector wins; also selects its data.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (search[k]) begin
        grant_any  = 1'b1;
        grant_idx  = BW_SEL'(k);
        grant_data = ch_data[k];
      end
    end
    grant = grant_any ? (N_CH'(1) << grant_idx) : '0;
  end

  // Accept strobe is suppressed during reset so no transfer completes then.
  assign o_ready = i_rst ? '0 : (grant & {N_CH{load}});

  // Output register: load the granted word, empty when nothing is granted,
  // hold while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
    end else if (load) begin
      if (grant_any) begin
        o_valid <= 1'b1;
        o_data  <= grant_data;
        o_ch    <= grant_idx;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer moves past the winner only on a real transfer in
  // round-robin mode; other modes leave it untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_reg <= '0;
    end else if ((i_mode == MODE_RR) && grant_any && load) begin
      ptr_reg <= (grant_idx == BW_SEL'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
